// File: rtl/mux_stim_pkg.sv
// rtl/mux_stim_pkg.sv - shared types and helpers for the mux stimulus/check stage
// Contents:
//   state_t  : sweep FSM states IDLE / HOLD / DONE
//   vec_t    : 3-bit stimulus vector, bit order {a,b,s}
//   ERR_MAX  : saturation value of the mismatch counter
//   to_gray  : binary index to Gray-code vector
//   mux_exp  : reference 2:1 mux result for a vector (s ? b : a)
package mux_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [2:0] vec_t;

    localparam logic [7:0] ERR_MAX = 8'd255;

    function automatic vec_t to_gray(vec_t v);
        return v ^ (v >> 1);
    endfunction

    // v = {a,b,s}
    function automatic logic mux_exp(vec_t v);
        return v[0] ? v[1] : v[2];
    endfunction

endpackage

// File: rtl/mux_stim_if.sv
// rtl/mux_stim_if.sv - stimulus/response bundle between the checker and the mux pair
// Signals:
//   a, b, s    : stimulus driven by the checker into both mux implementations
//   w_in, y_in : outputs of the two mux implementations back to the checker
// Modports:
//   master : checker side (drives a/b/s, samples w_in/y_in)
//   slave  : mux pair side
interface mux_stim_if;
    logic a;
    logic b;
    logic s;
    logic w_in;
    logic y_in;

    modport master (output a, b, s, input w_in, y_in);
    modport slave  (input a, b, s, output w_in, y_in);
endinterface

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - per-vector hold counter with wrap and settle-point flags
// Parameters: HOLD_CYCLES (counter runs 0..HOLD_CYCLES-1), SETTLE_CYCLES (sample point)
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : force counter to 0 (has priority over en_i)
//   en_i      : advance counter this cycle
//   wrap_o    : counter is at its last value (HOLD_CYCLES-1)
//   settle_o  : counter equals SETTLE_CYCLES
module hold_timer #(
    parameter int HOLD_CYCLES   = 7,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic wrap_o,
    output logic settle_o
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign wrap_o   = (cnt_q == CW'(HOLD_CYCLES - 1));
    assign settle_o = (cnt_q == CW'(SETTLE_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mux_stim_checker.sv
// rtl/mux_stim_checker.sv - clocked exhaustive sweep and self-check of a 2:1 mux pair
// Optional feature macro: MUX_STIM_XCHECK_EN (adds w_in!=y_in and X/Z as mismatch causes)
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a sweep (only looked at in IDLE)
//   gray_mode  : 1 = Gray vector order, 0 = binary; captured on start
//   mux        : a/b/s stimulus out, w_in/y_in responses in
//   busy       : sweep in progress
//   done       : one-cycle pulse after the last pass
//   err_cnt    : saturating mismatch count
//   first_err  : {a,b,s} of the first mismatching vector of the sweep
module mux_stim_checker
    import mux_stim_pkg::*;
#(
    parameter int HOLD_CYCLES   = 7,
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              gray_mode,
    mux_stim_if.master        mux,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt,
    output logic [2:0]        first_err
);
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          gray_q, gray_d;
    vec_t          vec_q, vec_d;
    logic [7:0]    err_q, err_d;
    vec_t          ferr_q, ferr_d;

    logic          wrap;
    logic          settle_hit;
    logic          mismatch;
    logic [2:0]    idx_nxt;

    hold_timer #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == IDLE),
        .en_i     (state_q == HOLD),
        .wrap_o   (wrap),
        .settle_o (settle_hit)
    );

    // The registered vector is what the muxes currently see, so the
    // expected value is derived from it rather than from the index.
    always_comb begin
`ifdef MUX_STIM_XCHECK_EN
        mismatch = (mux.w_in !== mux_exp(vec_q)) || (mux.y_in !== mux_exp(vec_q)) ||
                   (mux.w_in !== mux.y_in) || $isunknown({mux.w_in, mux.y_in});
`else
        mismatch = (mux.w_in != mux_exp(vec_q)) || (mux.y_in != mux_exp(vec_q));
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        gray_d  = gray_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        idx_nxt = idx_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HOLD;
                    gray_d  = gray_mode;
                    idx_d   = 3'd0;
                    pass_d  = '0;
                    vec_d   = 3'd0;
                    err_d   = 8'd0;
                    ferr_d  = 3'd0;
                end
            end
            HOLD: begin
                if (settle_hit && mismatch) begin
                    // Saturation keeps err_q nonzero, so zero means first of this sweep.
                    if (err_q == 8'd0) begin
                        ferr_d = vec_q;
                    end
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 8'd1;
                    end
                end
                if (wrap) begin
                    if (idx_q != 3'd7) begin
                        idx_d = idx_nxt;
                        vec_d = gray_q ? to_gray(idx_nxt) : idx_nxt;
                    end else if (pass_q != PW'(NUM_PASSES - 1)) begin
                        idx_d  = 3'd0;
                        pass_d = pass_q + PW'(1);
                        vec_d  = 3'd0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            pass_q  <= '0;
            gray_q  <= 1'b0;
            vec_q   <= 3'd0;
            err_q   <= 8'd0;
            ferr_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            gray_q  <= gray_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    assign mux.a     = vec_q[2];
    assign mux.b     = vec_q[1];
    assign mux.s     = vec_q[0];
    assign busy      = (state_q == HOLD);
    assign done      = (state_q == DONE);
    assign err_cnt   = err_q;
    assign first_err = ferr_q;
endmodule

// File: tb/tb_mux_stim_checker.sv
// tb/tb_mux_stim_checker.sv - randomized self-checking bench for mux_stim_checker
module tb_mux_stim_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, gray0 = 1'b0;
    logic       start1 = 1'b0, gray1 = 1'b0;
    logic       busy0, done0, busy1, done1, busy2, done2;
    logic [7:0] err0, err1, err2;
    logic [2:0] fe0, fe1, fe2;

    // fault injection for the mux pair seen by u0
    logic       stuck0 = 1'b0;
    logic [7:0] wbad0  = 8'd0;
    logic [7:0] ybad0  = 8'd0;

    int n_checks = 0;
    int n_errors = 0;

    int bin_ord  [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int gray_ord [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    mux_stim_if if0 ();
    mux_stim_if if1 ();
    mux_stim_if if2 ();

    function automatic logic ref_mux(logic a, logic b, logic s);
        return s ? b : a;
    endfunction

    function automatic logic ref_mux_v(int v);
        logic [2:0] t;
        t = 3'(v);
        return ref_mux(t[2], t[1], t[0]);
    endfunction

    assign if0.w_in = stuck0 ? 1'b0 :
                      (ref_mux(if0.a, if0.b, if0.s) ^ wbad0[{if0.a, if0.b, if0.s}]);
    assign if0.y_in = ref_mux(if0.a, if0.b, if0.s) ^ ybad0[{if0.a, if0.b, if0.s}];
    assign if1.w_in = ref_mux(if1.a, if1.b, if1.s);
    assign if1.y_in = ~ref_mux(if1.a, if1.b, if1.s);
    assign if2.w_in = ref_mux(if2.a, if2.b, if2.s);
    assign if2.y_in = ~ref_mux(if2.a, if2.b, if2.s);

    mux_stim_checker u0 (
        .clk(clk), .rst(rst), .start(start0), .gray_mode(gray0), .mux(if0),
        .busy(busy0), .done(done0), .err_cnt(err0), .first_err(fe0)
    );

    mux_stim_checker #(.HOLD_CYCLES(2), .SETTLE_CYCLES(1), .NUM_PASSES(15)) u1 (
        .clk(clk), .rst(rst), .start(start1), .gray_mode(gray1), .mux(if1),
        .busy(busy1), .done(done1), .err_cnt(err1), .first_err(fe1)
    );

    mux_stim_checker #(.HOLD_CYCLES(2), .SETTLE_CYCLES(1), .NUM_PASSES(33)) u2 (
        .clk(clk), .rst(rst), .start(start1), .gray_mode(gray1), .mux(if2),
        .busy(busy2), .done(done2), .err_cnt(err2), .first_err(fe2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sweep on u0 with the current fault setup, checked against the
    // vector order table and a per-vector mismatch count.
    task automatic run_sweep0(input logic g, input string tag);
        logic [2:0] seen[$];
        int         cyc;
        int         exp_err;
        int         exp_fe;
        int         v;
        logic       bad;
        cyc     = 0;
        exp_err = 0;
        exp_fe  = 0;
        for (int i = 0; i < 8; i++) begin
            v   = g ? gray_ord[i] : bin_ord[i];
            bad = (stuck0 ? ref_mux_v(v) : wbad0[v]) | ybad0[v];
            if (bad) begin
                if (exp_err == 0) exp_fe = v;
                exp_err++;
            end
        end
        @(negedge clk);
        gray0  = g;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check_eq({tag, "_busy_start"}, 32'(busy0), 32'd1);
        while (!done0 && cyc < 200) begin
            seen.push_back({if0.a, if0.b, if0.s});
            cyc++;
            @(negedge clk);
        end
        check_eq({tag, "_done_cycle"}, 32'(cyc + 1), 32'd57);
        check_eq({tag, "_busy_in_done"}, 32'(busy0), 32'd0);
        check_eq({tag, "_seq_len"}, 32'(seen.size()), 32'd56);
        for (int k = 0; k < seen.size() && k < 56; k++) begin
            v = g ? gray_ord[k / 7] : bin_ord[k / 7];
            check_eq({tag, "_vec"}, 32'(seen[k]), 32'(v));
            if (g && k > 0 && seen[k] != seen[k - 1])
                check_eq({tag, "_gray_1bit"}, 32'($countones(seen[k] ^ seen[k - 1])), 32'd1);
        end
        check_eq({tag, "_err_cnt"}, 32'(err0), 32'(exp_err));
        check_eq({tag, "_first_err"}, 32'(fe0), 32'(exp_fe));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done0), 32'd0);
        @(negedge clk);
        check_eq({tag, "_abs_hold"}, 32'({if0.a, if0.b, if0.s}), 32'(g ? gray_ord[7] : bin_ord[7]));
        check_eq({tag, "_err_keep"}, 32'(err0), 32'(exp_err));
    endtask

    initial begin : main
        int  cnt;
        bool_flags: begin end
        // reset state
        repeat (2) @(negedge clk);
        check_eq("rst_abs", 32'({if0.a, if0.b, if0.s}), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_done", 32'(done0), 32'd0);
        check_eq("rst_err", 32'(err0), 32'd0);
        check_eq("rst_fe", 32'(fe0), 32'd0);
        rst = 1'b0;

        // async reset mid-HOLD at vector 3 with a nonzero error count
        stuck0 = 1'b1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cnt = 0;
        while (err0 != 8'd1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("mid_err_seen", 32'(err0), 32'd1);
        check_eq("mid_vec", 32'({if0.a, if0.b, if0.s}), 32'd3);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_abs", 32'({if0.a, if0.b, if0.s}), 32'd0);
        check_eq("arst_busy", 32'(busy0), 32'd0);
        check_eq("arst_err", 32'(err0), 32'd0);
        check_eq("arst_done", 32'(done0), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_eq("arst_no_done", 32'(done0), 32'd0);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("post_rst_idle", 32'({busy0, done0}), 32'd0);
        end

        // directed sweeps
        stuck0 = 1'b0;
        run_sweep0(1'b0, "ideal_bin");
        run_sweep0(1'b1, "ideal_gray");
        stuck0 = 1'b1;
        run_sweep0(1'b0, "stuck_bin");
        run_sweep0(1'b1, "stuck_gray");
        stuck0 = 1'b0;

        // randomized fault patterns and order
        for (int r = 0; r < 4; r++) begin
            wbad0 = 8'($urandom);
            ybad0 = 8'($urandom_range(0, 1) == 1 ? $urandom : 0);
            run_sweep0(1'($urandom), "rand");
        end
        wbad0 = 8'd0;
        ybad0 = 8'd0;

        // start held high through DONE
        stuck0 = 1'b1;
        @(negedge clk);
        gray0  = 1'b0;
        start0 = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!done0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("held_done", 32'(done0), 32'd1);
        check_eq("held_err", 32'(err0), 32'd4);
        check_eq("held_fe", 32'(fe0), 32'd3);
        @(negedge clk);
        check_eq("held_idle", 32'({busy0, done0}), 32'd0);
        @(negedge clk);
        check_eq("held_restart", 32'(busy0), 32'd1);
        check_eq("held_err_clr", 32'(err0), 32'd0);
        start0 = 1'b0;
        stuck0 = 1'b0;
        cnt = 0;
        while (!done0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("held2_done", 32'(done0), 32'd1);
        check_eq("held2_err", 32'(err0), 32'd0);

        // multi-pass count and saturation, y_in inverted
        begin
            bit got1, got2;
            got1 = 1'b0;
            got2 = 1'b0;
            @(negedge clk);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            cnt = 0;
            while (!(got1 && got2) && cnt < 3000) begin
                if (done1 && !got1) begin
                    got1 = 1'b1;
                    check_eq("p15_len", 32'(cnt + 1), 32'(8 * 2 * 15 + 1));
                    check_eq("p15_err", 32'(err1), 32'd120);
                    check_eq("p15_fe", 32'(fe1), 32'd0);
                end
                if (done2 && !got2) begin
                    got2 = 1'b1;
                    check_eq("sat_err", 32'(err2), 32'd255);
                end
                cnt++;
                @(negedge clk);
            end
            check_eq("multi_done_seen", 32'({got1, got2}), 32'd3);
            repeat (3) @(negedge clk);
            check_eq("sat_hold", 32'(err2), 32'd255);
            check_eq("p15_hold", 32'(err1), 32'd120);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
